sharpx1_vram_arbiter: RTL and testbench

- Single-port video RAM arbiter for the X1 core. Shares one synchronous VRAM port (text/attribute/GRAM plane) between three requesters:
  - ROM/font download (ioctl path)
  - CRTC display fetch
  - Z80 CPU, stalled via WAIT.
- Sits between the core's CPU bus decode, the video fetch logic that produces ce_pix/video, and the VRAM instance.
- Guarantees fixed-latency display reads and bounded CPU starvation.

---
 rtl/sharpx1_vram_pkg.sv | 6 +
 rtl/sharpx1_vram_tagpipe.sv | 24 ++
 rtl/sharpx1_vram_arbiter.sv | 131 +++++++++++++
 tb/tb_sharpx1_vram_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sharpx1_vram_pkg.sv
// rtl/sharpx1_vram_pkg.sv - shared types and constants for the X1 VRAM arbiter
package sharpx1_vram_pkg;
  typedef enum logic [2:0] {TAG_NONE, TAG_DL, TAG_VID, TAG_VIDMISS, TAG_CPU} tag_t;
  typedef enum logic [1:0] {IDLE, PEND, ISSUED, DONE} cpu_state_t;
  localparam int STARVE_W = 5;
endpackage

// File: rtl/sharpx1_vram_tagpipe.sv
// rtl/sharpx1_vram_tagpipe.sv - owner tag shift register aligned with VRAM read latency
module sharpx1_vram_tagpipe
  import sharpx1_vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t stage [DEPTH];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];
endmodule

// File: rtl/sharpx1_vram_arbiter.sv
// rtl/sharpx1_vram_arbiter.sv - single-port VRAM arbiter for download, display fetch and Z80 CPU
module sharpx1_vram_arbiter
  import sharpx1_vram_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_valid,
  output logic [DW-1:0] vid_data,
  output logic          vid_miss,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_wait_n,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  cpu_state_t          state;
  logic                op_rd;
  logic [2:0]          lat_cnt;
  logic [STARVE_W-1:0] starve;
  tag_t                tag_in;
  tag_t                tag_out;
  logic                cpu_req, cpu_elig, boost, dl_grant, cpu_grant, vid_grant, cur_rd;

  always_comb begin
    cpu_req   = ((state == IDLE) && (cpu_rd || cpu_wr)) || (state == PEND);
    cpu_elig  = cpu_req && !dl_active;
    boost     = (starve == STARVE_W'(STARVE_MAX));
    dl_grant  = dl_active && dl_wr;
    cpu_grant = !dl_grant && cpu_elig && (boost || !vid_req);
    vid_grant = !dl_grant && vid_req && !(cpu_elig && boost);
    cur_rd    = (state == IDLE) ? cpu_rd : op_rd;
    // A fetch that loses still gets a tag so its fixed-latency vid_valid slot is kept.
    if (vid_req && !vid_grant) tag_in = TAG_VIDMISS;
    else if (vid_grant)        tag_in = TAG_VID;
    else if (dl_grant)         tag_in = TAG_DL;
    else if (cpu_grant)        tag_in = TAG_CPU;
    else                       tag_in = TAG_NONE;
  end

  assign cpu_wait_n = !cpu_req && (state != ISSUED);

  sharpx1_vram_tagpipe #(.DEPTH(RAM_LAT + 1)) u_tagpipe (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= '0;
    end else begin
      ram_we <= 1'b0;
      if (dl_grant) begin
        ram_addr <= dl_addr;
        ram_we   <= 1'b1;
        ram_din  <= dl_data;
      end else if (cpu_grant) begin
        ram_addr <= cpu_addr;
        ram_we   <= !cur_rd;
        ram_din  <= cpu_din;
      end else if (vid_grant) begin
        ram_addr <= vid_addr;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vid_valid <= 1'b0;
      vid_miss  <= 1'b0;
      vid_data  <= '0;
    end else begin
      vid_valid <= (tag_out == TAG_VID) || (tag_out == TAG_VIDMISS);
      vid_miss  <= (tag_out == TAG_VIDMISS);
      vid_data  <= (tag_out == TAG_VID) ? ram_dout : '0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_rd    <= 1'b0;
      lat_cnt  <= '0;
      starve   <= '0;
      cpu_dout <= '0;
    end else begin
      if (cpu_grant)
        starve <= '0;
      else if (!dl_active && cpu_req && vid_grant && !boost)
        starve <= starve + STARVE_W'(1);

      case (state)
        IDLE: if (cpu_rd || cpu_wr) begin
          op_rd   <= cpu_rd;
          lat_cnt <= '0;
          state   <= cpu_grant ? ISSUED : PEND;
        end
        PEND: if (cpu_grant) begin
          lat_cnt <= '0;
          state   <= ISSUED;
        end
        ISSUED: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (op_rd && lat_cnt == 3'(RAM_LAT)) cpu_dout <= ram_dout;
          if (!op_rd || lat_cnt == 3'(RAM_LAT + 1)) state <= DONE;
        end
        DONE: if (!cpu_rd && !cpu_wr) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sharpx1_vram_arbiter.sv
// tb/tb_sharpx1_vram_arbiter.sv - scoreboard bench for the X1 VRAM arbiter (RAM_LAT 1 and 3)
module tb_sharpx1_vram_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 0, dl_wr = 0;
  logic [15:0] dl_addr = 0;
  logic [7:0]  dl_data = 0;
  logic        vid_req = 0;
  logic [15:0] vid_addr = 0;
  logic        vid_valid, vid_miss;
  logic [7:0]  vid_data;
  logic        cpu_rd = 0, cpu_wr = 0;
  logic [15:0] cpu_addr = 0;
  logic [7:0]  cpu_din = 0;
  logic [7:0]  cpu_dout;
  logic        cpu_wait_n;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic        vid_req3 = 0, cpu_rd3 = 0;
  logic [15:0] vid_addr3 = 0, cpu_addr3 = 0;
  logic        vid_valid3, vid_miss3, cpu_wait_n3, ram_we3;
  logic [7:0]  vid_data3, cpu_dout3, ram_din3, ram_dout3, p3_0, p3_1;
  logic [15:0] ram_addr3;

  logic [7:0]  mem1   [0:65535];
  logic [7:0]  mem3   [0:65535];
  logic [7:0]  shadow [0:65535];

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       miss;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sharpx1_vram_arbiter #(.AW(16), .DW(8), .RAM_LAT(1), .STARVE_MAX(15)) dut (
    .clk_sys(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_valid(vid_valid), .vid_data(vid_data), .vid_miss(vid_miss),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  sharpx1_vram_arbiter #(.AW(16), .DW(8), .RAM_LAT(3), .STARVE_MAX(15)) dut3 (
    .clk_sys(clk), .reset(reset), .dl_active(1'b0), .dl_wr(1'b0),
    .dl_addr(16'h0000), .dl_data(8'h00), .vid_req(vid_req3), .vid_addr(vid_addr3),
    .vid_valid(vid_valid3), .vid_data(vid_data3), .vid_miss(vid_miss3),
    .cpu_rd(cpu_rd3), .cpu_wr(1'b0), .cpu_addr(cpu_addr3), .cpu_din(8'h00),
    .cpu_dout(cpu_dout3), .cpu_wait_n(cpu_wait_n3), .ram_addr(ram_addr3),
    .ram_we(ram_we3), .ram_din(ram_din3), .ram_dout(ram_dout3)
  );

  // Synchronous VRAM models: latency 1 and latency 3.
  always @(posedge clk) begin
    if (ram_we) mem1[ram_addr] <= ram_din;
    ram_dout <= mem1[ram_addr];
    if (ram_we3) mem3[ram_addr3] <= ram_din3;
    p3_0      <= mem3[ram_addr3];
    p3_1      <= p3_0;
    ram_dout3 <= p3_1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        check("vid_lost", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (vid_valid) begin
        if (q.size() == 0) begin
          check("vid_spurious", vid_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("vid_cycle", cyc, e.due);
          check("vid_data", vid_data, e.data);
          check("vid_miss", vid_miss, e.miss);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_txn(input logic rd, input logic [15:0] a, input logic [7:0] d,
                         input int exp_lat, input string tag);
    int lat;
    cpu_addr = a;
    cpu_din  = d;
    cpu_rd   = rd;
    cpu_wr   = !rd;
    lat = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!rd && k == 1) begin
        check({tag, "_ram_we"}, ram_we, 1'b1);
        check({tag, "_ram_addr"}, ram_addr, a);
        check({tag, "_ram_din"}, ram_din, d);
      end
      if (cpu_wait_n) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    next_cycle();
    cpu_rd = 0;
    cpu_wr = 0;
  endtask

  initial begin
    int vk, wk;
    for (int k = 0; k < 65536; k++) begin
      mem1[k]   = k[7:0] ^ 8'hC3;
      mem3[k]   = k[7:0] ^ 8'hC3;
      shadow[k] = k[7:0] ^ 8'hC3;
    end
    mem1[16'h1234] = 8'hA5;
    mem3[16'h1234] = 8'hA5;
    shadow[16'h1234] = 8'hA5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_addr", ram_addr, 16'h0000);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_din", ram_din, 8'h00);
    check("rst_vid_valid", vid_valid, 1'b0);
    check("rst_vid_data", vid_data, 8'h00);
    check("rst_vid_miss", vid_miss, 1'b0);
    check("rst_cpu_dout", cpu_dout, 8'h00);
    check("rst_wait_n", cpu_wait_n, 1'b1);
    check("rst_wait_n3", cpu_wait_n3, 1'b1);
    next_cycle();
    reset = 0;
    next_cycle();

    // Single uncontended display fetch.
    vid_req  = 1;
    vid_addr = 16'h1234;
    q.push_back('{cyc + 3, 8'hA5, 1'b0});
    next_cycle();
    vid_req = 0;
    @(negedge clk);
    check("vid_ram_addr", ram_addr, 16'h1234);
    repeat (4) next_cycle();

    // Uncontended CPU write then read-back.
    cpu_txn(1'b0, 16'h0010, 8'h5A, 2, "cpu_wr");
    shadow[16'h0010] = 8'h5A;
    next_cycle();
    cpu_txn(1'b1, 16'h0010, 8'h00, 4, "cpu_rd");
    check("cpu_rd_dout", cpu_dout, shadow[16'h0010]);
    next_cycle();

    // Continuous display fetch starving a CPU read until the boost.
    fork
      cpu_txn(1'b1, 16'h0020, 8'h00, 19, "starve");
      begin
        for (int i = 0; i < 20; i++) begin
          vid_req  = 1;
          vid_addr = 16'(16'h0100 + i);
          q.push_back('{cyc + 3, (i == 15) ? 8'h00 : shadow[16'(16'h0100 + i)], i == 15});
          next_cycle();
        end
        vid_req = 0;
      end
    join
    check("starve_dout", cpu_dout, shadow[16'h0020]);
    repeat (4) next_cycle();

    // Download burst with a colliding fetch and a CPU read held off by dl_active.
    fork
      cpu_txn(1'b1, 16'h0030, 8'h00, 10, "dl_cpu");
      begin
        for (int i = 0; i < 7; i++) begin
          dl_active = (i < 6);
          dl_wr     = (i < 4);
          dl_addr   = 16'(i);
          dl_data   = 8'(8'h10 + i);
          vid_req   = (i == 1);
          vid_addr  = 16'h0200;
          if (i == 1) q.push_back('{cyc + 3, 8'h00, 1'b1});
          if (i < 4) shadow[i] = 8'(8'h10 + i);
          if (i >= 1 && i <= 4) begin
            @(negedge clk);
            check("dl_ram_we", ram_we, 1'b1);
            check("dl_ram_addr", ram_addr, 16'(i - 1));
            check("dl_ram_din", ram_din, 8'(8'h10 + i - 1));
          end
          next_cycle();
        end
        dl_active = 0;
        dl_wr     = 0;
        vid_req   = 0;
      end
    join
    check("dl_cpu_dout", cpu_dout, shadow[16'h0030]);
    repeat (4) next_cycle();

    // Reset while a CPU read is issued and a fetch is in flight.
    cpu_addr = 16'h0040;
    cpu_rd   = 1;
    next_cycle();
    vid_req  = 1;
    vid_addr = 16'h0300;
    next_cycle();
    vid_req = 0;
    cpu_rd  = 0;
    reset   = 1;
    #1;
    check("mid_rst_ram_addr", ram_addr, 16'h0000);
    check("mid_rst_vid_valid", vid_valid, 1'b0);
    check("mid_rst_cpu_dout", cpu_dout, 8'h00);
    check("mid_rst_wait_n", cpu_wait_n, 1'b1);
    repeat (2) next_cycle();
    reset = 0;
    #1;
    check("post_rst_wait_n", cpu_wait_n, 1'b1);
    repeat (6) next_cycle();
    cpu_txn(1'b1, 16'h0040, 8'h00, 4, "post_rst");
    check("post_rst_dout", cpu_dout, shadow[16'h0040]);
    next_cycle();

    // RAM_LAT=3 build: fetch and CPU read in the same cycle.
    vid_req3  = 1;
    vid_addr3 = 16'h1234;
    cpu_rd3   = 1;
    cpu_addr3 = 16'h0050;
    vk = -1;
    wk = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (vid_valid3 && vk < 0) begin
        vk = k;
        check("l3_vid_data", vid_data3, 8'hA5);
        check("l3_vid_miss", vid_miss3, 1'b0);
      end
      if (cpu_wait_n3 && wk < 0) wk = k;
      next_cycle();
      vid_req3 = 0;
      if (wk >= 0) cpu_rd3 = 0;
    end
    check("l3_vid_lat", vk, 5);
    check("l3_cpu_lat", wk, 7);
    check("l3_cpu_dout", cpu_dout3, shadow[16'h0050]);

    repeat (4) next_cycle();
    check("vid_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
